modular_inverse: RTL
====================

# modular_inverse

Iterative modular-inverse engine: accepts an operand `a` and an odd modulus `m`, and returns `a^-1 mod m`. It uses the binary extended-Euclidean algorithm, doing one step per clock. It is the inverse-direction companion to the team's combinational-plus-register modular multiplier and feeds NWC parameter and twiddle precompute logic. It has valid/ready handshakes on both sides and processes one operation at a time.

## Interface
- `DATA_WIDTH`, default 8: width of the operand, modulus and result.
- `MAX_STEPS`, default 4*DATA_WIDTH: bound on RUN cycles; exceeding it is an error.
- `clk`  in  1: clock; all logic is rising-edge.
- `rst`  in  1: reset, synchronous, active-high; one clock, one synchronous active-high reset.
- `in_valid`  in  1: operand present.
- `in_ready`  out  1: engine idle, can accept.
- `a`  in  DATA_WIDTH: operand, expected in 1..m-1.
- `modulus`  in  DATA_WIDTH: odd modulus, ≥3.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes result.
- `result`  out  DATA_WIDTH: inverse; 0 when `err`=1.
- `err`  out  1: no inverse exists or input is illegal.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- Internal registers: u, v (DATA_WIDTH); x1, x2 (DATA_WIDTH, always kept in 0..m-1); m (latched); step counter.
- **IDLE:** `in_ready`=1. On `in_valid && in_ready` it latches `m` and loads u=a, v=m, x1=1, x2=0.
  - If a==0, a≥m, m[0]==0, or m<3: go directly to DONE with err=1 and result=0.
  - Otherwise go to RUN.
- **RUN:** exactly one action per cycle, in this priority order:
  1. u==0, v==0, or step counter reaches MAX_STEPS → DONE, err=1, result=0.
  2. u==1 → DONE, result=x1.
  3. v==1 → DONE, result=x2.
  4. u even → u=u>>1; x1 = x1 even ? x1>>1 : (x1+m)>>1.
  5. v even → same halving rule applied to v and x2.
  6. u≥v → u=u−v; x1=(x1−x2) mod m.
  7. Otherwise → v=v−u; x2=(x2−x1) mod m.
- Width rule: x+m is computed in DATA_WIDTH+1 bits before the shift. For a modular subtract, if the DATA_WIDTH+1-bit difference is negative, add m.
- **DONE:** `out_valid`=1; `result` and `err` are held stable. Leave for IDLE on `out_ready`.
- The step counter clears on accept and increments once per RUN cycle.

## Timing
- Reset values: `in_ready`=0 during reset (1 from the first post-reset cycle, i.e. IDLE), `out_valid`=0, `result`=0, `err`=0; the FSM is in IDLE.
- Accept at edge k. With N RUN cycles, where the Nth cycle is the terminating one, `out_valid` first goes high in the cycle after edge k+N.
- An illegal input gives N=0: `out_valid` is high the cycle after edge k.
- Latency is N+1 cycles, with N ≤ MAX_STEPS.
- `out_valid` and `out_ready` sampled high at edge j: IDLE from edge j, so `in_ready`=1 in the next cycle. No back-to-back accept happens in the same cycle as the output handshake.
- `out_ready` held low: DONE is held indefinitely with no change to outputs.
- `in_valid` while not IDLE: ignored, because `in_ready`=0.
- `rst` asserted mid-RUN or in DONE: at the next edge the engine returns to IDLE, all outputs go to their reset values, and the in-flight operation is discarded.

## Structure
- Package `mod_inv_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE}` for the state.
  - Default-width localparams.
- Sub-module `mod_half_sub`, combinational. It provides (x+m·x[0])>>1 and (x−y) mod m over DATA_WIDTH+1 internal bits, and is instantiated once per x-register path.
- Top level holds the FSM, the u/v/x datapath and the step counter.

## Test plan
- m=17, a=3 → `result`=6, `err`=0, N=6. Path: v=14, v=7, v=4, v=2, v=1, terminate via x2.
- m=17, a=1 → `result`=1, N=1 (u==1 on the first RUN cycle). Also m=17, a=16 → `result`=16.
- Illegal inputs:
  - a=0, m=17 → `err`=1, `result`=0, `out_valid` the cycle after accept.
  - m=18, a=5 → same response.
  - a=17, m=17 → same response.
- Non-coprime: m=255, a=5 → `err`=1 via the u==0 path, `result`=0, N ≤ 32.
- Back-pressure: hold `out_ready`=0 for 10 cycles after a=3, m=17 → `result`=6 stays stable, `in_ready`=0 throughout. Then `out_ready`=1 → `in_ready`=1 next cycle.
- Exhaustive m=251 plus reset: all a in 1..250 with random back-pressure; check a·result mod 251 == 1 and N ≤ 32. Assert `rst` mid-RUN → IDLE next edge with outputs zeroed. Then a=3, m=17 → 6.

Source files
------------

// File: rtl/mod_inv_pkg.sv
// Shared types and default widths for the binary extended-Euclidean inverse engine.
package mod_inv_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_STEPS  = 4 * DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/mod_half_sub.sv
// Combinational x-path helpers: modular halving (x + m*x[0]) >> 1 and modular subtract (x - y) mod m.
module mod_half_sub #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] m,
  output logic [DATA_WIDTH-1:0] half,
  output logic [DATA_WIDTH-1:0] diff
);

  localparam int unsigned XW = DATA_WIDTH + 1;

  logic [XW-1:0] sum;
  logic [XW-1:0] d;
  logic [XW-1:0] dm;

  // Extra bit keeps the carry of x+m and the borrow of x-y.
  always_comb begin
    sum  = XW'(x) + (x[0] ? XW'(m) : XW'(0));
    half = DATA_WIDTH'(sum >> 1);
    d    = XW'(x) - XW'(y);
    dm   = d + XW'(m);
    diff = d[DATA_WIDTH] ? DATA_WIDTH'(dm) : DATA_WIDTH'(d);
  end

endmodule

// File: rtl/modular_inverse.sv
// Iterative a^-1 mod m engine, one binary extended-Euclidean step per clock, valid/ready on both sides.
module modular_inverse
  import mod_inv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_STEPS  = 4 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] modulus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  err
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(MAX_STEPS + 1);

  state_t         state_q, state_d;
  logic [W-1:0]   u_q, u_d, v_q, v_d;
  logic [W-1:0]   x1_q, x1_d, x2_q, x2_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   result_q, result_d;
  logic           err_q, err_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W-1:0]   x1_half, x1_diff, x2_half, x2_diff;
  logic           illegal;

  mod_half_sub #(.DATA_WIDTH(W)) u_x1_path (
    .x    (x1_q),
    .y    (x2_q),
    .m    (m_q),
    .half (x1_half),
    .diff (x1_diff)
  );

  mod_half_sub #(.DATA_WIDTH(W)) u_x2_path (
    .x    (x2_q),
    .y    (x1_q),
    .m    (m_q),
    .half (x2_half),
    .diff (x2_diff)
  );

  assign illegal = (a == '0) || (a >= modulus) || !modulus[0] || (modulus < W'(3));

  // Next-state and datapath update; exactly one algorithm action per RUN cycle.
  always_comb begin
    state_d     = state_q;
    u_d         = u_q;
    v_d         = v_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    m_d         = m_q;
    result_d    = result_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d   = modulus;
          u_d   = a;
          v_d   = modulus;
          x1_d  = W'(1);
          x2_d  = '0;
          cnt_d = '0;
          if (illegal) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            err_d       = 1'b1;
            result_d    = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if ((u_q == '0) || (v_q == '0) || (cnt_q == CW'(MAX_STEPS - 1))) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
          result_d    = '0;
        end else if (u_q == W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          err_d       = 1'b0;
          result_d    = x1_q;
        end else if (v_q == W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          err_d       = 1'b0;
          result_d    = x2_q;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_diff;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_diff;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      u_q         <= '0;
      v_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      m_q         <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      u_q         <= u_d;
      v_q         <= v_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      m_q         <= m_d;
      result_q    <= result_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  // Ready is masked while reset is held so nothing is advertised before the engine is live.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule
